// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a byte stream little-endian into 32-bit words; emits a one-cycle
// word_valid pulse in the cycle after the fourth byte of each word.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_stb,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt_r;
    logic [31:0] shift_r;
    logic        valid_r;

    // Shift bytes in from the top so the first byte ends up in bits [7:0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 2'd0;
            shift_r <= 32'd0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (byte_stb) begin
                shift_r <= {byte_in, shift_r[31:8]};
                cnt_r   <= cnt_r + 2'd1;
                valid_r <= (cnt_r == 2'(BYTES_PER_WORD - 1));
            end else begin
                shift_r <= shift_r;
                cnt_r   <= cnt_r;
            end
        end
    end

    assign word_valid = valid_r;
    assign word       = shift_r;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory: length, data words,
// checksum. Holds the CPU while loading and reports done or error.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter  int IMEM_DEPTH  = 256,
    parameter  int INSTR_WIDTH = 32,
    localparam int ADDR_W      = $clog2(IMEM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [INSTR_WIDTH-1:0] wr_data,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   error
);

    loader_state_t      state_r;
    logic [7:0]         len_lo_r;
    logic [LEN_W+1:0]   bytes_left_r;
    logic [7:0]         csum_r;
    logic [ADDR_W-1:0]  addr_r;
    logic               byte_ready_r;
    logic               cpu_hold_r;
    logic               done_r;
    logic               error_r;

    logic               xfer_s;
    logic [LEN_W-1:0]   len_s;
    logic               word_valid_s;
    logic [31:0]        word_s;

    assign xfer_s = byte_valid && byte_ready_r;
    assign len_s  = {byte_data, len_lo_r};

    imem_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_stb   (xfer_s && (state_r == ST_DATA)),
        .byte_in    (byte_data),
        .word_valid (word_valid_s),
        .word       (word_s)
    );

    // Loader FSM, word address, checksum accumulator and registered status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            len_lo_r     <= 8'd0;
            bytes_left_r <= '0;
            csum_r       <= 8'd0;
            addr_r       <= '0;
            byte_ready_r <= 1'b0;
            cpu_hold_r   <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            // Saturate at the last word so a full-depth load cannot wrap to 0.
            if (word_valid_s && (addr_r != ADDR_W'(IMEM_DEPTH - 1))) begin
                addr_r <= addr_r + 1'b1;
            end
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_r      <= ST_LEN_LO;
                        addr_r       <= '0;
                        csum_r       <= 8'd0;
                        done_r       <= 1'b0;
                        error_r      <= 1'b0;
                        byte_ready_r <= 1'b1;
                        cpu_hold_r   <= 1'b1;
                    end
                end
                ST_LEN_LO: begin
                    if (xfer_s) begin
                        len_lo_r <= byte_data;
                        state_r  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (xfer_s) begin
                        if (len_s == 16'd0) begin
                            state_r <= ST_CSUM;
                        end else if (len_s > LEN_W'(IMEM_DEPTH)) begin
                            state_r      <= ST_ERR;
                            error_r      <= 1'b1;
                            byte_ready_r <= 1'b0;
                        end else begin
                            state_r      <= ST_DATA;
                            bytes_left_r <= {len_s, 2'b00};
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer_s) begin
                        csum_r       <= csum_r + byte_data;
                        bytes_left_r <= bytes_left_r - 1'b1;
                        if (bytes_left_r == (LEN_W + 2)'(1)) begin
                            state_r <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (xfer_s) begin
                        byte_ready_r <= 1'b0;
                        if (byte_data == csum_r) begin
                            state_r    <= ST_DONE;
                            done_r     <= 1'b1;
                            cpu_hold_r <= 1'b0;
                        end else begin
                            state_r <= ST_ERR;
                            error_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    byte_ready_r <= 1'b0;
                    cpu_hold_r   <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_r;
    assign wr_en      = word_valid_s;
    assign wr_addr    = addr_r;
    assign wr_data    = INSTR_WIDTH'(word_s);
    assign cpu_hold   = cpu_hold_r;
    assign done       = done_r;
    assign error      = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames with hand-computed words and checksums.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int checks = 0;
    int failures = 0;

    logic [7:0]  dat [0:1023];
    logic [7:0]  wa_q [$];
    logic [31:0] wd_q [$];

    imem_loader #(.IMEM_DEPTH(256), .INSTR_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Record every memory write away from the active edge.
    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic idle_gap(input bit en);
        if (en) begin
            repeat ($urandom_range(0, 2)) begin
                start = ($urandom_range(0, 3) == 0);
                @(negedge clk);
                start = 1'b0;
            end
        end
    endtask

    task automatic do_start();
        wa_q.delete();
        wd_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load(input int n, input logic [7:0] cs, input bit gaps);
        logic [15:0] len;
        len = 16'(n);
        idle_gap(gaps); send(len[7:0]);
        idle_gap(gaps); send(len[15:8]);
        for (int k = 0; k < 4 * n; k++) begin
            idle_gap(gaps);
            send(dat[k]);
        end
        idle_gap(gaps);
        send(cs);
    endtask

    task automatic check_writes(input int n, input string tag);
        check({tag, "_nwrites"}, 32'(wa_q.size()), 32'(n));
        for (int i = 0; i < wa_q.size() && i < n; i++) begin
            check({tag, "_addr"}, 32'(wa_q[i]), 32'(i));
            check({tag, "_data"}, wd_q[i], {dat[4*i+3], dat[4*i+2], dat[4*i+1], dat[4*i]});
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, wr_data, 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    task automatic set_small_frame();
        logic [7:0] f [0:7];
        f = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        for (int i = 0; i < 8; i++) dat[i] = f[i];
    endtask

    initial begin
        logic [7:0] sum;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Good N=2 frame, checksum 0xB6.
        set_small_frame();
        do_start();
        check("start_hold", 32'(cpu_hold), 32'd1);
        check("start_ready", 32'(byte_ready), 32'd1);
        load(2, 8'hB6, 1'b0);
        check("good_done", 32'(done), 32'd1);
        check("good_hold", 32'(cpu_hold), 32'd0);
        check("good_error", 32'(error), 32'd0);
        check("good_ready", 32'(byte_ready), 32'd0);
        check_writes(2, "good");

        // Start and a byte together in DONE: start wins, byte not consumed.
        wa_q.delete();
        wd_q.delete();
        start = 1'b1;
        byte_valid = 1'b1;
        byte_data = 8'h02;
        @(negedge clk);
        start = 1'b0;
        byte_valid = 1'b0;
        check("simul_ready", 32'(byte_ready), 32'd1);
        check("simul_done", 32'(done), 32'd0);
        load(2, 8'hB6, 1'b0);
        check("simul_done2", 32'(done), 32'd1);
        check_writes(2, "simul");

        // Bad checksum.
        do_start();
        load(2, 8'hB7, 1'b0);
        check("badcs_error", 32'(error), 32'd1);
        check("badcs_done", 32'(done), 32'd0);
        check("badcs_hold", 32'(cpu_hold), 32'd1);
        check_writes(2, "badcs");

        // Oversize N=257.
        do_start();
        send(8'h01);
        send(8'h01);
        @(negedge clk);
        check("over_error", 32'(error), 32'd1);
        check("over_ready", 32'(byte_ready), 32'd0);
        check("over_hold", 32'(cpu_hold), 32'd1);
        check("over_nwrites", 32'(wa_q.size()), 32'd0);

        // Empty load.
        do_start();
        load(0, 8'h00, 1'b0);
        check("empty_done", 32'(done), 32'd1);
        check("empty_error", 32'(error), 32'd0);
        check("empty_nwrites", 32'(wa_q.size()), 32'd0);

        // Full-depth load.
        sum = 8'd0;
        for (int k = 0; k < 1024; k++) begin
            dat[k] = 8'(k * 7 + 3);
            sum += dat[k];
        end
        do_start();
        load(256, sum, 1'b0);
        check("full_done", 32'(done), 32'd1);
        check("full_last_addr", 32'(wa_q[$]), 32'd255);
        check_writes(256, "full");

        // Gappy stream with ignored mid-load starts.
        set_small_frame();
        do_start();
        load(2, 8'hB6, 1'b1);
        check("gap_done", 32'(done), 32'd1);
        check("gap_error", 32'(error), 32'd0);
        check("gap_hold", 32'(cpu_hold), 32'd0);
        check_writes(2, "gap");

        // Reset after six data bytes.
        do_start();
        send(8'h02);
        send(8'h00);
        for (int k = 0; k < 6; k++) send(dat[k]);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_nwrites", 32'(wa_q.size()), 32'd1);
        check("midrst_wr_en", 32'(wr_en), 32'd0);
        do_start();
        load(2, 8'hB6, 1'b0);
        check("after_rst_done", 32'(done), 32'd1);
        check_writes(2, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
